calendar_date: RTL and testbench
================================

# calendar_date

Parametrised day/month/year calendar counter for the digital clock; successor to the fixed 30-day date counter. Advances one day per `tick` pulse from the hour counter's midnight rollover. Supports a fixed-length month mode or true month lengths with leap years, validated field loads from the set-time logic, and month/year carry pulses. Fields are placed on a shared, output-enabled data bus for the display mux.

## Interface
- `MODE`, 1: 0 = every month is `FIXED_DAYS` long; 1 = true month lengths (Feb 28/29).
- `FIXED_DAYS`, 30: month length in mode 0; legal range 28..31.
- `YEAR_W`, 7: year field width; must be ≥ 5 (the bus width equals `YEAR_W`).
- `YEAR_MAX`, 99: last year value; must be < 2^`YEAR_W`. The year wraps from `YEAR_MAX` to 0.
- `YEAR_INIT`, 0: year value after reset.
- `LEAP_EN`, 1: mode 1 only; when 1, a year with `year[1:0]==0` is a leap year.
- `clk` in 1: rising-edge clock.
- `clear_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle day-advance pulse.
- `load` in 1: field load strobe.
- `load_sel` in 2: selects the field to load: 0 = day, 1 = month, 2 = year, 3 = none.
- `data` in `YEAR_W`: load value, zero-extended; day uses bits [4:0] and month uses bits [3:0].
- `oe` in 1: bus output enable.
- `rd_sel` in 2: selects the field driven on the bus: 0 = day, 1 = month, 2 = year, 3 = zero.
- `day` out 5: current day, 1..31.
- `month` out 4: current month, 1..12.
- `year` out `YEAR_W`: current year, 0..`YEAR_MAX`.
- `databus` out `YEAR_W`: the field selected by `rd_sel`, zero-extended, when `oe`=1; otherwise 0.
- `month_carry` out 1: one-cycle pulse on each month wrap.
- `year_carry` out 1: one-cycle pulse on each year wrap.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation

**Reset**
- `day`=1, `month`=1, `year`=`YEAR_INIT`.
- `month_carry`, `year_carry` and `load_err` are 0.
- `databus` follows `oe` and `rd_sel` combinationally.

**Month length (`last`)**
- Mode 0: `last` = `FIXED_DAYS`.
- Mode 1: `last` = 31 for months 1, 3, 5, 7, 8, 10, 12.
- Mode 1: `last` = 30 for months 4, 6, 9, 11.
- Mode 1, February: `last` = 29 when the year is a leap year, otherwise 28.
- `last` is evaluated from the current registered `month` and `year`.

**Tick** (when `load`=0)
- If `day` < `last`: `day`+1.
- If `day` = `last`: `day`=1 and `month_carry` pulses. In the same update:
  - if `month` < 12: `month`+1;
  - if `month` = 12: `month`=1 and `year_carry` pulses;
  - on that year increment, if `year` = `YEAR_MAX` then `year`=0, otherwise `year`+1.

**Load**
- `load` has priority: a `tick` in the same cycle is dropped (not deferred).
- A load never produces carry pulses.
- Day: accepted if 1 ≤ `data` ≤ `last` of the current month and year.
- Month: accepted if 1 ≤ `data` ≤ 12.
- Year: accepted if `data` ≤ `YEAR_MAX`.
- `load_sel`=3 is a no-op and does not raise an error.
- Rejected load: all fields hold and `load_err`=1 for one cycle.
- Accepted month or year load: if `day` exceeds the new `last`, `day` is clamped to the new `last` in the same update. Example: 31 Mar with month loaded to 2 in a non-leap year gives 28 Feb.

**Out-of-range state**
- Unreachable in normal operation.
- If `day` > `last` ever occurs, the next `tick` treats it as `day` = `last`: the day wraps and the month advances.

## Timing
- All fields and pulses are registered.
- A `tick` or `load` sampled at edge N is visible on the outputs after edge N.
- `month_carry` and `year_carry` are high for the cycle after edge N, coincident with the wrapped values.
- `load_err` is high for the cycle after edge N.
- `databus` is combinational from the registers, `oe` and `rd_sel`: zero cycles of latency.
- Back-to-back ticks on consecutive cycles are each counted. There is no minimum tick spacing.
- `clear_n` assertion mid-operation forces the reset values immediately. Pulses drop at once.
- The first `tick` is honoured at the first rising edge after `clear_n` deasserts.

## Test plan
- **Reset.** `clear_n` low, `YEAR_INIT`=24 → `day`=1, `month`=1, `year`=24. Assert `oe`, `rd_sel`=2 → `databus`=24.
- **Month and year wrap, mode 1.** 31 Dec 99 plus `tick` → 1 Jan 0; `month_carry`=1 and `year_carry`=1 for exactly one cycle.
- **Leap handling.** 28 Feb with `year`=24 plus `tick` → 29 Feb, then next `tick` → 1 Mar. With `year`=23, 28 Feb plus `tick` → 1 Mar.
- **Mode 0, `FIXED_DAYS`=30.** 30 Jun plus `tick` → 1 Jul. 29 Jan plus two ticks → 1 Feb, with no 31st day.
- **Load validation.** Month 4: load day 31 → `load_err` pulses and the date holds. Load month 13 → error. 31 Mar, load month 2 with `year`=23 → 28 Feb, no error.
- **Load/tick collision and async reset.** `load` day 10 plus `tick` in the same cycle → `day`=10, no carry. `clear_n` pulsed between clock edges mid-count → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/calendar_date.sv
// calendar_date: day/month/year counter with leap years, validated loads, carry pulses and bus readout
module calendar_date #(
  parameter int MODE       = 1,
  parameter int FIXED_DAYS = 30,
  parameter int YEAR_W     = 7,
  parameter int YEAR_MAX   = 99,
  parameter int YEAR_INIT  = 0,
  parameter int LEAP_EN    = 1
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              tick,
  input  logic              load,
  input  logic [1:0]        load_sel,
  input  logic [YEAR_W-1:0] data,
  input  logic              oe,
  input  logic [1:0]        rd_sel,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [YEAR_W-1:0] databus,
  output logic              month_carry,
  output logic              year_carry,
  output logic              load_err
);

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              mc_q, mc_d, yc_q, yc_d, err_q, err_d;
  logic [4:0]        last_cur, last_mon, last_yr, last_new;
  logic              ok;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    if (MODE == 0) return 5'(FIXED_DAYS);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return (LEAP_EN != 0 && y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  assign last_cur = month_len(month_q, year_q);
  assign last_mon = month_len(data[3:0], year_q);
  assign last_yr  = month_len(month_q, data);
  assign last_new = load_sel == 2'd1 ? last_mon : last_yr;

  // Next-state: load has priority over tick; a tick at or past the last day wraps the month
  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    mc_d    = 1'b0;
    yc_d    = 1'b0;
    err_d   = 1'b0;
    ok      = 1'b0;
    if (load) begin
      case (load_sel)
        2'd0:    ok = data >= YEAR_W'(1) && data <= YEAR_W'(last_cur);
        2'd1:    ok = data >= YEAR_W'(1) && data <= YEAR_W'(12);
        2'd2:    ok = data <= YEAR_W'(YEAR_MAX);
        default: ok = 1'b1;
      endcase
      err_d = !ok;
      if (ok && load_sel == 2'd0) day_d = data[4:0];
      if (ok && load_sel == 2'd1) month_d = data[3:0];
      if (ok && load_sel == 2'd2) year_d = data;
      if (ok && (load_sel == 2'd1 || load_sel == 2'd2) && day_q > last_new) day_d = last_new;
    end else if (tick) begin
      if (day_q < last_cur) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d   = 5'd1;
        mc_d    = 1'b1;
        yc_d    = month_q >= 4'd12;
        month_d = yc_d ? 4'd1 : month_q + 4'd1;
        if (yc_d) year_d = year_q == YEAR_W'(YEAR_MAX) ? '0 : year_q + YEAR_W'(1);
      end
    end
  end

  // Field and pulse registers, cleared asynchronously by clear_n
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YEAR_W'(YEAR_INIT);
      mc_q    <= 1'b0;
      yc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      mc_q    <= mc_d;
      yc_q    <= yc_d;
      err_q   <= err_d;
    end
  end

  assign day         = day_q;
  assign month       = month_q;
  assign year        = year_q;
  assign month_carry = mc_q;
  assign year_carry  = yc_q;
  assign load_err    = err_q;
  assign databus     = !oe           ? '0 :
                       rd_sel == 2'd0 ? YEAR_W'(day_q) :
                       rd_sel == 2'd1 ? YEAR_W'(month_q) :
                       rd_sel == 2'd2 ? year_q : '0;

endmodule

// File: tb/tb_calendar_date.sv
// tb_calendar_date: directed checks of a true-calendar instance (0) and a fixed 30-day instance (1)
module tb_calendar_date;

  logic            clk = 1'b0;
  logic            clear_n = 1'b0;
  logic [1:0]      tick = '0, load = '0, oe = '0, mc, yc, err;
  logic [1:0][1:0] load_sel = '0, rd_sel = '0;
  logic [1:0][6:0] data = '0, year, databus;
  logic [1:0][4:0] day;
  logic [1:0][3:0] month;
  int              n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  calendar_date #(.MODE(1), .YEAR_INIT(24)) u_cal (
    .clk(clk), .clear_n(clear_n), .tick(tick[0]), .load(load[0]), .load_sel(load_sel[0]),
    .data(data[0]), .oe(oe[0]), .rd_sel(rd_sel[0]), .day(day[0]), .month(month[0]),
    .year(year[0]), .databus(databus[0]), .month_carry(mc[0]), .year_carry(yc[0]),
    .load_err(err[0])
  );

  calendar_date #(.MODE(0), .FIXED_DAYS(30)) u_fix (
    .clk(clk), .clear_n(clear_n), .tick(tick[1]), .load(load[1]), .load_sel(load_sel[1]),
    .data(data[1]), .oe(oe[1]), .rd_sel(rd_sel[1]), .day(day[1]), .month(month[1]),
    .year(year[1]), .databus(databus[1]), .month_carry(mc[1]), .year_carry(yc[1]),
    .load_err(err[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input int u, input string tag, input int d, input int m, input int y);
    check({tag, ".day"}, int'(day[u]), d);
    check({tag, ".month"}, int'(month[u]), m);
    check({tag, ".year"}, int'(year[u]), y);
  endtask

  task automatic cyc(input int u, input logic t, input logic l, input logic [1:0] s, input logic [6:0] d);
    tick[u] = t;
    load[u] = l;
    load_sel[u] = s;
    data[u] = d;
    @(posedge clk);
    #1;
    tick[u] = 1'b0;
    load[u] = 1'b0;
  endtask

  task automatic set_date(input int u, input int d, input int m, input int y);
    cyc(u, 0, 1, 2'd2, 7'(y));
    cyc(u, 0, 1, 2'd1, 7'(m));
    cyc(u, 0, 1, 2'd0, 7'(d));
  endtask

  initial begin
    #12;
    check_date(0, "reset", 1, 1, 24);
    check("reset.mc", int'(mc[0]), 0);
    check("reset.yc", int'(yc[0]), 0);
    check("reset.err", int'(err[0]), 0);
    check("bus.oe0", int'(databus[0]), 0);
    oe[0] = 1'b1;
    rd_sel[0] = 2'd2;
    #1 check("bus.year", int'(databus[0]), 24);
    rd_sel[0] = 2'd1;
    #1 check("bus.month", int'(databus[0]), 1);
    rd_sel[0] = 2'd3;
    #1 check("bus.zero", int'(databus[0]), 0);
    @(negedge clk) clear_n = 1'b1;

    set_date(0, 31, 12, 99);
    check_date(0, "set", 31, 12, 99);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "ywrap", 1, 1, 0);
    check("ywrap.mc", int'(mc[0]), 1);
    check("ywrap.yc", int'(yc[0]), 1);
    cyc(0, 0, 0, 2'd0, 7'd0);
    check("ywrap.mc_drop", int'(mc[0]), 0);
    check("ywrap.yc_drop", int'(yc[0]), 0);

    set_date(0, 28, 2, 24);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "leap29", 29, 2, 24);
    check("leap29.mc", int'(mc[0]), 0);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "leap_mar", 1, 3, 24);
    check("leap_mar.mc", int'(mc[0]), 1);
    check("leap_mar.yc", int'(yc[0]), 0);
    set_date(0, 28, 2, 23);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "noleap", 1, 3, 23);

    set_date(0, 15, 4, 23);
    cyc(0, 0, 1, 2'd0, 7'd31);
    check_date(0, "ld_d31", 15, 4, 23);
    check("ld_d31.err", int'(err[0]), 1);
    cyc(0, 0, 0, 2'd0, 7'd0);
    check("ld_d31.err_drop", int'(err[0]), 0);
    cyc(0, 0, 1, 2'd0, 7'd0);
    check("ld_d0.err", int'(err[0]), 1);
    cyc(0, 0, 1, 2'd1, 7'd13);
    check_date(0, "ld_m13", 15, 4, 23);
    check("ld_m13.err", int'(err[0]), 1);
    cyc(0, 0, 1, 2'd2, 7'd100);
    check_date(0, "ld_y100", 15, 4, 23);
    check("ld_y100.err", int'(err[0]), 1);
    cyc(0, 0, 1, 2'd3, 7'd5);
    check_date(0, "ld_none", 15, 4, 23);
    check("ld_none.err", int'(err[0]), 0);

    set_date(0, 31, 3, 23);
    cyc(0, 0, 1, 2'd1, 7'd2);
    check_date(0, "clamp_m", 28, 2, 23);
    check("clamp_m.err", int'(err[0]), 0);
    set_date(0, 29, 2, 24);
    cyc(0, 0, 1, 2'd2, 7'd25);
    check_date(0, "clamp_y", 28, 2, 25);

    set_date(0, 30, 4, 23);
    cyc(0, 1, 1, 2'd0, 7'd10);
    check_date(0, "collide", 10, 4, 23);
    check("collide.mc", int'(mc[0]), 0);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "after_collide", 11, 4, 23);

    set_date(1, 30, 6, 5);
    cyc(1, 1, 0, 2'd0, 7'd0);
    check_date(1, "fix_jul", 1, 7, 5);
    check("fix_jul.mc", int'(mc[1]), 1);
    set_date(1, 29, 1, 5);
    cyc(1, 1, 0, 2'd0, 7'd0);
    check_date(1, "fix_j30", 30, 1, 5);
    cyc(1, 1, 0, 2'd0, 7'd0);
    check_date(1, "fix_feb", 1, 2, 5);
    cyc(1, 0, 1, 2'd0, 7'd31);
    check("fix_d31.err", int'(err[1]), 1);
    oe[1] = 1'b1;
    rd_sel[1] = 2'd0;
    #1 check("fix_bus.day", int'(databus[1]), 1);

    cyc(0, 1, 0, 2'd0, 7'd0);
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "pre_rst", 13, 4, 23);
    #2 clear_n = 1'b0;
    #1;
    check_date(0, "async_rst", 1, 1, 24);
    check_date(1, "async_rst_fix", 1, 1, 0);
    @(negedge clk) clear_n = 1'b1;
    cyc(0, 1, 0, 2'd0, 7'd0);
    check_date(0, "first_tick", 2, 1, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
